segled_tx: RTL and testbench

Serial transmitter for the board's 8-digit seven-segment display shift-register chain (SEGLED_CLK/CLR/DO/PEN). It converts an 8-nibble hex value, decimal points and per-digit blanks into a 64-bit active-low segment frame. It shifts the frame out MSB-first on a generated serial clock and re-enables the display afterwards. It sits beside the game core in the top level and shows score and debug values; it is the outbound counterpart to the keypad scanner's inbound path.

---
 rtl/segled_pkg.sv | 32 +++
 rtl/segled_tx_if.sv | 21 ++
 rtl/segled_tx_hex7seg.sv | 33 +++
 rtl/segled_tx.sv | 117 +++++++++++
 tb/tb_segled_tx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/segled_pkg.sv
// Shared types and constants for the seven-segment serial transmitter.
package segled_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int FRAME_BITS = 64;
    localparam int DIGITS     = 8;

    // Active-high gfedcba glyphs for the hex digits.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/segled_tx_if.sv
// Host-side request/status bundle of the seven-segment transmitter.
interface segled_tx_if;

    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        start;
    logic        busy;
    logic        done;

    modport master (
        output data, dp, blank, start,
        input  busy, done
    );

    modport slave (
        input  data, dp, blank, start,
        output busy, done
    );

endinterface

// File: rtl/segled_tx_hex7seg.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module hex7seg
    import segled_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup for one digit.
    always_comb begin
        seg = GLYPH_0;
        case (nibble)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            4'hF:    seg = GLYPH_F;
            default: seg = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/segled_tx.sv
// Serial transmitter for the 8-digit seven-segment shift-register chain.
// Builds a 64-bit active-low frame and shifts it out MSB-first, holding
// the display enable low while the chain contents are in motion.
module segled_tx
    import segled_pkg::*;
#(
    parameter int unsigned DIV = 4
)
(
    input  logic       clk,
    input  logic       rst,
    segled_tx_if.slave bus,
    output logic       segled_clk,
    output logic       segled_clr,
    output logic       segled_do,
    output logic       segled_pen
);

    localparam logic [7:0] HALF_LAST = 8'(DIV - 1);
    localparam logic [6:0] BIT_LAST  = 7'(FRAME_BITS - 1);

    state_t                state;
    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] frame_next;
    logic [6:0]            bit_cnt;
    logic [7:0]            half_cnt;
    logic                  phase;      // 0 = low half of a bit, 1 = high half
    logic [6:0]            glyph [DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hex7seg u_hex (
            .nibble (bus.data[i*4 +: 4]),
            .seg    (glyph[i])
        );
    end

    // Assemble the active-low frame; blanking overrides glyph and dp.
    always_comb begin
        frame_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.blank[i]) begin
                frame_next[i*8 +: 8] = 8'hFF;
            end else begin
                frame_next[i*8 +: 8] = {~bus.dp[i], ~glyph[i]};
            end
        end
    end

    // Frame sequencer; the serial clock output follows the phase bit one
    // cycle late so data is already stable for a full half-period at the rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= 7'd0;
            half_cnt   <= 8'd0;
            phase      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            segled_clk <= 1'b0;
            segled_do  <= 1'b0;
            segled_clr <= 1'b0;
            segled_pen <= 1'b1;
        end else begin
            segled_clr <= 1'b1;
            bus.done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    frame      <= frame_next;
                    bit_cnt    <= 7'd0;
                    half_cnt   <= 8'd0;
                    phase      <= 1'b0;
                    bus.busy   <= 1'b1;
                    segled_pen <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    segled_clk <= phase;
                    if (!phase) begin
                        segled_do <= frame[FRAME_BITS-1];
                    end
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= 8'd0;
                        phase    <= ~phase;
                        if (phase) begin
                            frame   <= {frame[FRAME_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 7'd1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= LATCH;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                LATCH: begin
                    segled_clk <= 1'b0;
                    segled_do  <= 1'b0;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    segled_pen <= 1'b1;
                    bit_cnt    <= 7'd0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segled_tx.sv
// Self-checking bench for segled_tx: two instances (DIV=4 and DIV=1) share
// clock and reset; a scoreboard of expected bytes is filled at stimulus time
// and compared against the bits captured on serial clock rises.
module tb_segled_tx;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    segled_tx_if bus4 ();
    segled_tx_if bus1 ();
    logic sclk4, sclr4, sdo4, pen4;
    logic sclk1, sclr1, sdo1, pen1;

    segled_tx #(.DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .bus(bus4.slave),
        .segled_clk(sclk4), .segled_clr(sclr4), .segled_do(sdo4), .segled_pen(pen4)
    );

    segled_tx #(.DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .segled_clk(sclk1), .segled_clr(sclr1), .segled_do(sdo1), .segled_pen(pen1)
    );

    logic [7:0] exp_q [$];
    logic       cap4 [$];
    logic       cap1 [$];
    int         rise4 [$];
    int         rise1 [$];
    int         done4 [$];
    int         done1 [$];
    int         stray = 0;
    int         early = 0;
    logic       sclk4_prev = 1'b0, sclk1_prev = 1'b0;
    logic       sdo4_prev = 1'b0, sdo1_prev = 1'b0;
    logic       busy4_prev = 1'b0, busy1_prev = 1'b0;

    // Monitor: capture data on serial clock rises, record done times, and
    // flag serial clock rises outside a frame, data moving while the serial
    // clock is high, and busy falling without done.
    always @(negedge clk) begin
        if (sclk4 && !sclk4_prev) begin
            cap4.push_back(sdo4);
            rise4.push_back(cyc);
        end
        if (sclk1 && !sclk1_prev) begin
            cap1.push_back(sdo1);
            rise1.push_back(cyc);
        end
        if (bus4.done) done4.push_back(cyc);
        if (bus1.done) done1.push_back(cyc);
        if ((sclk4 && !sclk4_prev && !bus4.busy) || (sclk1 && !sclk1_prev && !bus1.busy) ||
            (sclk4 && (sdo4 !== sdo4_prev)) || (sclk1 && (sdo1 !== sdo1_prev))) begin
            stray <= stray + 1;
        end
        if (!rst && ((busy4_prev && !bus4.busy && !bus4.done) ||
                     (busy1_prev && !bus1.busy && !bus1.done))) begin
            early <= early + 1;
        end
        sclk4_prev <= sclk4;
        sclk1_prev <= sclk1;
        sdo4_prev  <= sdo4;
        sdo1_prev  <= sdo1;
        busy4_prev <= bus4.busy;
        busy1_prev <= bus1.busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] ref_byte(input logic [3:0] n, input logic d, input logic b);
        return b ? 8'hFF : {~d, ~ref_glyph(n)};
    endfunction

    // One full frame on the selected instance; optional start re-pulses at
    // frame cycles 5 and 300 together with a data change mid-frame.
    task automatic run_frame(input bit sel, input logic [31:0] d, input logic [7:0] p,
                             input logic [7:0] b, input bit rep, input string tag);
        int         t0;
        int         n;
        int         dn;
        int         span;
        int         first;
        int         div;
        logic       bits [$];
        logic [7:0] got;
        logic [7:0] exp;
        div = sel ? 1 : 4;
        for (int i = 7; i >= 0; i--) exp_q.push_back(ref_byte(d[i*4 +: 4], p[i], b[i]));
        cap4.delete(); cap1.delete(); rise4.delete(); rise1.delete(); done4.delete(); done1.delete();
        @(negedge clk); #1;
        if (sel) begin
            bus1.data = d; bus1.dp = p; bus1.blank = b; bus1.start = 1'b1;
        end else begin
            bus4.data = d; bus4.dp = p; bus4.blank = b; bus4.start = 1'b1;
        end
        @(posedge clk); #2;
        t0 = cyc;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        n  = 0;
        dn = 0;
        while (dn == 0 && n < 2000) begin
            @(posedge clk); #2;
            n++;
            if (sel) bus1.start = rep && (n == 5 || n == 300);
            else     bus4.start = rep && (n == 5 || n == 300);
            if (rep && n == 5) begin
                if (sel) bus1.data = ~d;
                else     bus4.data = ~d;
            end
            dn = sel ? done1.size() : done4.size();
        end
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        check({tag, "_done_seen"}, 64'(dn != 0), 64'd1);
        repeat (6) @(posedge clk);
        #2;
        if (sel) begin
            bits  = cap1;
            dn    = done1.size();
            span  = (done1.size() > 0) ? done1[0] - t0 : -1;
            first = (rise1.size() > 0) ? rise1[0] - t0 : -1;
        end else begin
            bits  = cap4;
            dn    = done4.size();
            span  = (done4.size() > 0) ? done4[0] - t0 : -1;
            first = (rise4.size() > 0) ? rise4[0] - t0 : -1;
        end
        check({tag, "_done_count"}, 64'(dn), 64'd1);
        check({tag, "_done_time"}, 64'(span), 64'(128 * div + 2));
        check({tag, "_first_rise"}, 64'(first), 64'(2 + div));
        check({tag, "_bit_count"}, 64'(bits.size()), 64'd64);
        while (bits.size() < 64) bits.push_back(1'bx);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) got[7 - j] = bits[k*8 + j];
            exp = exp_q.pop_front();
            check($sformatf("%s_byte%0d", tag, k), 64'(got), 64'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus4.data = 32'h0; bus4.dp = 8'h0; bus4.blank = 8'h0; bus4.start = 1'b0;
        bus1.data = 32'h0; bus1.dp = 8'h0; bus1.blank = 8'h0; bus1.start = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 64'(bus4.busy), 64'd0);
        check("rst_done", 64'(bus4.done), 64'd0);
        check("rst_sclk", 64'(sclk4), 64'd0);
        check("rst_sdo", 64'(sdo4), 64'd0);
        check("rst_clr", 64'(sclr4), 64'd0);
        check("rst_pen", 64'(pen4), 64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("clr_after_release", 64'(sclr4), 64'd1);

        // Reset asserted while idle.
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("idle_rst_clr", 64'(sclr4), 64'd0);
        check("idle_rst_pen", 64'(pen4), 64'd1);
        check("idle_rst_busy", 64'(bus4.busy), 64'd0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_clr_release", 64'(sclr4), 64'd1);

        run_frame(1'b0, 32'h0000_0000, 8'h00, 8'h00, 1'b0, "zeros");
        run_frame(1'b0, 32'h0123_ABCF, 8'b1000_0001, 8'h00, 1'b0, "hexmix");
        run_frame(1'b0, 32'h8888_8888, 8'h00, 8'b0000_1111, 1'b0, "blank");
        run_frame(1'b0, 32'hFEDC_9876, 8'h0F, 8'h00, 1'b1, "repulse");

        // Reset in the middle of a frame, around bit 20.
        @(negedge clk); #1;
        bus4.data = 32'hDEAD_BEEF; bus4.dp = 8'h00; bus4.blank = 8'h00; bus4.start = 1'b1;
        @(posedge clk); #2;
        bus4.start = 1'b0;
        cap4.delete(); done4.delete();
        n = 0;
        while (cap4.size() < 20 && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check("abort_bit20_reached", 64'(cap4.size()), 64'd20);
        check("abort_busy_before", 64'(bus4.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus4.busy), 64'd0);
        check("abort_done", 64'(bus4.done), 64'd0);
        check("abort_sclk", 64'(sclk4), 64'd0);
        check("abort_sdo", 64'(sdo4), 64'd0);
        check("abort_clr", 64'(sclr4), 64'd0);
        check("abort_pen", 64'(pen4), 64'd1);
        @(negedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_no_done", 64'(done4.size()), 64'd0);
        check("abort_stays_idle", 64'(bus4.busy), 64'd0);

        run_frame(1'b1, 32'h4567_89DE, 8'h5A, 8'h24, 1'b0, "div1");

        check("stray_sclk_or_data", 64'(stray), 64'd0);
        check("busy_early_drop", 64'(early), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
